// File: rtl/draw_field_fx_pkg.sv
// Shared colour, palette and flash-state definitions for the playfield renderer.
package draw_field_fx_pkg;

  localparam int unsigned TETRIS_COLORS_WIDTH = 3;

  localparam logic [23:0] COLOR_BRICKS_0 = 24'h000000;
  localparam logic [23:0] COLOR_BRICKS_1 = 24'h00ffff;
  localparam logic [23:0] COLOR_BRICKS_2 = 24'h0000ff;
  localparam logic [23:0] COLOR_BRICKS_3 = 24'hff8000;
  localparam logic [23:0] COLOR_BRICKS_4 = 24'hffff00;
  localparam logic [23:0] COLOR_BRICKS_5 = 24'h00ff00;
  localparam logic [23:0] COLOR_BRICKS_6 = 24'h800080;
  localparam logic [23:0] COLOR_BRICKS_7 = 24'hff0000;
  localparam logic [23:0] COLOR_BORDERS  = 24'h606060;
  localparam logic [23:0] COLOR_FLASH    = 24'hffffff;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } flash_state_e;

  function automatic logic [23:0] palette(input logic [TETRIS_COLORS_WIDTH-1:0] idx);
    logic [23:0] color;
    unique case (idx)
      3'd0:    color = COLOR_BRICKS_0;
      3'd1:    color = COLOR_BRICKS_1;
      3'd2:    color = COLOR_BRICKS_2;
      3'd3:    color = COLOR_BRICKS_3;
      3'd4:    color = COLOR_BRICKS_4;
      3'd5:    color = COLOR_BRICKS_5;
      3'd6:    color = COLOR_BRICKS_6;
      default: color = COLOR_BRICKS_7;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/field_geom.sv
// Registered geometry decode of one brick grid: region hit, brick-area hit and cell col/row.
module field_geom #(
  parameter int unsigned PIX_WIDTH = 12,
  parameter int unsigned X0        = 300,
  parameter int unsigned Y0        = 200,
  parameter int unsigned CNT_X     = 10,
  parameter int unsigned CNT_Y     = 20,
  parameter int unsigned BRICK_X   = 30,
  parameter int unsigned BRICK_Y   = 30,
  parameter int unsigned BORDER_X  = 2,
  parameter int unsigned BORDER_Y  = 2,
  parameter int unsigned COL_W     = 4,
  parameter int unsigned ROW_W     = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PIX_WIDTH-1:0] pix_x_i,
  input  logic [PIX_WIDTH-1:0] pix_y_i,
  output logic                 region_o,
  output logic                 brick_o,
  output logic [COL_W-1:0]     col_o,
  output logic [ROW_W-1:0]     row_o
);

  localparam int unsigned PITCH_X = BRICK_X + BORDER_X;
  localparam int unsigned PITCH_Y = BRICK_Y + BORDER_Y;
  localparam int unsigned X_END   = X0 + CNT_X * PITCH_X + BORDER_X;
  localparam int unsigned Y_END   = Y0 + CNT_Y * PITCH_Y + BORDER_Y;

  logic [PIX_WIDTH-1:0] rel_x, rel_y, off_x, off_y;
  logic                 in_x, in_y, brick_x, brick_y;
  logic                 region_d, region_q, brick_d, brick_q;
  logic [COL_W-1:0]     col_d, col_q;
  logic [ROW_W-1:0]     row_d, row_q;

  always_comb begin
    in_x  = (pix_x_i >= PIX_WIDTH'(X0)) && (pix_x_i < PIX_WIDTH'(X_END));
    in_y  = (pix_y_i >= PIX_WIDTH'(Y0)) && (pix_y_i < PIX_WIDTH'(Y_END));
    rel_x = pix_x_i - PIX_WIDTH'(X0);
    rel_y = pix_y_i - PIX_WIDTH'(Y0);
    // Offsets underflow left of the first border strip; the >= test masks that case.
    off_x = rel_x - PIX_WIDTH'(BORDER_X);
    off_y = rel_y - PIX_WIDTH'(BORDER_Y);
    brick_x = (rel_x >= PIX_WIDTH'(BORDER_X)) &&
              ((off_x % PIX_WIDTH'(PITCH_X)) < PIX_WIDTH'(BRICK_X));
    brick_y = (rel_y >= PIX_WIDTH'(BORDER_Y)) &&
              ((off_y % PIX_WIDTH'(PITCH_Y)) < PIX_WIDTH'(BRICK_Y));
    region_d = in_x && in_y;
    brick_d  = region_d && brick_x && brick_y;
    col_d    = brick_d ? COL_W'(off_x / PIX_WIDTH'(PITCH_X)) : '0;
    row_d    = brick_d ? ROW_W'(off_y / PIX_WIDTH'(PITCH_Y)) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      region_q <= 1'b0;
      brick_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      region_q <= region_d;
      brick_q  <= brick_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  assign region_o = region_q;
  assign brick_o  = brick_q;
  assign col_o    = col_q;
  assign row_o    = row_q;

endmodule

// File: rtl/draw_field_fx.sv
// Renders the main playfield and next-block preview, with a frame-timed row flash animation.
module draw_field_fx
  import draw_field_fx_pkg::*;
#(
  parameter int unsigned PIX_WIDTH    = 12,
  parameter int unsigned BRICK_X      = 30,
  parameter int unsigned BRICK_Y      = 30,
  parameter int unsigned BORDER_X     = 2,
  parameter int unsigned BORDER_Y     = 2,
  parameter int unsigned COL_CNT      = 10,
  parameter int unsigned ROW_CNT      = 20,
  parameter int unsigned MAIN_X       = 300,
  parameter int unsigned MAIN_Y       = 200,
  parameter int unsigned NBP_CNT      = 6,
  parameter int unsigned NBP_X        = 670,
  parameter int unsigned NBP_Y        = 200,
  parameter int unsigned FLASH_CNT    = 3,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic [PIX_WIDTH-1:0]                                   pix_x_i,
  input  logic [PIX_WIDTH-1:0]                                   pix_y_i,
  input  logic                                                   frame_start_i,
  input  logic [ROW_CNT-1:0][COL_CNT-1:0][TETRIS_COLORS_WIDTH-1:0] gd_field,
  input  logic [3:0][3:0][3:0]                                   gd_next_block_data,
  input  logic [1:0]                                             gd_next_block_rotation,
  input  logic [TETRIS_COLORS_WIDTH-1:0]                         gd_next_block_color,
  input  logic                                                   gd_next_block_draw_en,
  input  logic [ROW_CNT-1:0]                                     flash_rows_i,
  input  logic                                                   flash_start_i,
  output logic                                                   flash_busy_o,
  output logic                                                   flash_done_o,
  output logic [23:0]                                            vga_data_o,
  output logic                                                   vga_data_en_o
);

  localparam int unsigned MCOL_W = (COL_CNT > 1) ? $clog2(COL_CNT) : 1;
  localparam int unsigned MROW_W = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
  localparam int unsigned PV_W   = (NBP_CNT > 1) ? $clog2(NBP_CNT) : 1;
  localparam int unsigned FR_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int unsigned PAIR_W = (FLASH_CNT > 1) ? $clog2(FLASH_CNT) : 1;

  logic              m_region, m_brick, p_region, p_brick;
  logic [MCOL_W-1:0] m_col;
  logic [MROW_W-1:0] m_row;
  logic [PV_W-1:0]   p_col, p_row;

  field_geom #(
    .PIX_WIDTH(PIX_WIDTH), .X0(MAIN_X), .Y0(MAIN_Y), .CNT_X(COL_CNT), .CNT_Y(ROW_CNT),
    .BRICK_X(BRICK_X), .BRICK_Y(BRICK_Y), .BORDER_X(BORDER_X), .BORDER_Y(BORDER_Y),
    .COL_W(MCOL_W), .ROW_W(MROW_W)
  ) u_main_geom (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pix_x_i  (pix_x_i),
    .pix_y_i  (pix_y_i),
    .region_o (m_region),
    .brick_o  (m_brick),
    .col_o    (m_col),
    .row_o    (m_row)
  );

  field_geom #(
    .PIX_WIDTH(PIX_WIDTH), .X0(NBP_X), .Y0(NBP_Y), .CNT_X(NBP_CNT), .CNT_Y(NBP_CNT),
    .BRICK_X(BRICK_X), .BRICK_Y(BRICK_Y), .BORDER_X(BORDER_X), .BORDER_Y(BORDER_Y),
    .COL_W(PV_W), .ROW_W(PV_W)
  ) u_preview_geom (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pix_x_i  (pix_x_i),
    .pix_y_i  (pix_y_i),
    .region_o (p_region),
    .brick_o  (p_brick),
    .col_o    (p_col),
    .row_o    (p_row)
  );

  flash_state_e      state_d, state_q;
  logic [FR_W-1:0]   frame_d, frame_q;
  logic [PAIR_W-1:0] pair_d, pair_q;
  logic [ROW_CNT-1:0] rows_d, rows_q;
  logic              done_d, done_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    pair_d  = pair_q;
    rows_d  = rows_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flash_start_i && (|flash_rows_i)) begin
          state_d = StOn;
          rows_d  = flash_rows_i;
          frame_d = '0;
          pair_d  = '0;
        end
      end
      StOn: begin
        if (frame_start_i) begin
          if (frame_q == FR_W'(FLASH_FRAMES - 1)) begin
            state_d = StOff;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      StOff: begin
        if (frame_start_i) begin
          if (frame_q == FR_W'(FLASH_FRAMES - 1)) begin
            frame_d = '0;
            if (pair_q == PAIR_W'(FLASH_CNT - 1)) begin
              state_d = StIdle;
              pair_d  = '0;
              rows_d  = '0;
              done_d  = 1'b1;
            end else begin
              state_d = StOn;
              pair_d  = pair_q + 1'b1;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      frame_q <= '0;
      pair_q  <= '0;
      rows_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      pair_q  <= pair_d;
      rows_q  <= rows_d;
      done_q  <= done_d;
    end
  end

  assign flash_busy_o = (state_q != StIdle);
  assign flash_done_o = done_q;

  logic [23:0]                    vga_data_d, vga_data_q;
  logic                           vga_en_d, vga_en_q;
  logic [TETRIS_COLORS_WIDTH-1:0] prev_idx;
  logic                           prev_inner;
  logic [1:0]                     prev_r, prev_c;

  always_comb begin
    vga_data_d = COLOR_BORDERS;
    vga_en_d   = 1'b0;
    prev_inner = (p_row >= PV_W'(1)) && (p_row <= PV_W'(NBP_CNT - 2)) &&
                 (p_col >= PV_W'(1)) && (p_col <= PV_W'(NBP_CNT - 2));
    prev_r     = 2'(p_row - PV_W'(1));
    prev_c     = 2'(p_col - PV_W'(1));
    prev_idx   = '0;
    if (prev_inner && gd_next_block_draw_en &&
        gd_next_block_data[gd_next_block_rotation][prev_r][prev_c]) begin
      prev_idx = gd_next_block_color;
    end
    // Main field wins over the preview wherever both regions claim a pixel.
    if (m_region) begin
      vga_en_d = 1'b1;
      if (m_brick) begin
        if (rows_q[m_row] && (state_q == StOn)) begin
          vga_data_d = COLOR_FLASH;
        end else if (rows_q[m_row] && (state_q == StOff)) begin
          vga_data_d = palette('0);
        end else begin
          vga_data_d = palette(gd_field[m_row][m_col]);
        end
      end
    end else if (p_region) begin
      vga_en_d = 1'b1;
      if (p_brick) begin
        vga_data_d = palette(prev_idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vga_data_q <= '0;
      vga_en_q   <= 1'b0;
    end else begin
      vga_data_q <= vga_data_d;
      vga_en_q   <= vga_en_d;
    end
  end

  assign vga_data_o    = vga_data_q;
  assign vga_data_en_o = vga_en_q;

endmodule

// File: tb/tb_draw_field_fx.sv
// Directed bench for draw_field_fx: pixel scoreboard with 2-cycle latency plus flash FSM checks.
module tb_draw_field_fx;
  import draw_field_fx_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [11:0]                 pix_x = '0, pix_y = '0;
  logic                        frame_start = 1'b0;
  logic [19:0][9:0][2:0]       gd_field = '0;
  logic [3:0][3:0][3:0]        nb_data = '0;
  logic [1:0]                  nb_rot = '0;
  logic [2:0]                  nb_color = '0;
  logic                        nb_en = 1'b0;
  logic [19:0]                 flash_rows = '0;
  logic                        flash_start = 1'b0;
  logic                        flash_busy_o, flash_done_o, vga_data_en_o;
  logic [23:0]                 vga_data_o;

  draw_field_fx u_dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .pix_x_i                (pix_x),
    .pix_y_i                (pix_y),
    .frame_start_i          (frame_start),
    .gd_field               (gd_field),
    .gd_next_block_data     (nb_data),
    .gd_next_block_rotation (nb_rot),
    .gd_next_block_color    (nb_color),
    .gd_next_block_draw_en  (nb_en),
    .flash_rows_i           (flash_rows),
    .flash_start_i          (flash_start),
    .flash_busy_o           (flash_busy_o),
    .flash_done_o           (flash_done_o),
    .vga_data_o             (vga_data_o),
    .vga_data_en_o          (vga_data_en_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic        en;
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pid = 0;
  int   done_seen = 0;
  logic last_busy, last_done;
  int   n_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One negedge; retire every scoreboard entry whose output is due now.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk($sformatf("pix%0d_en", e.id), {31'b0, vga_data_en_o}, {31'b0, e.en});
      chk($sformatf("pix%0d_data", e.id), {8'b0, vga_data_o}, {8'b0, e.data});
    end
  endtask

  task automatic send(input int x, input int y, input logic en, input logic [23:0] data);
    tick();
    pix_x = 12'(x);
    pix_y = 12'(y);
    exp_q.push_back('{id: pid, en: en, data: data, due: cyc + 2});
    pid++;
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  task automatic start_flash(input logic [19:0] rows);
    tick();
    flash_rows  = rows;
    flash_start = 1'b1;
    tick();
    flash_start = 1'b0;
    flash_rows  = '0;
  endtask

  task automatic frame_pulse();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    last_busy = flash_busy_o;
    last_done = flash_done_o;
    if (flash_done_o) done_seen++;
    tick();
    if (flash_done_o) done_seen++;
  endtask

  task automatic run_to_idle(output int n);
    n = -1;
    for (int p = 1; p <= 60; p++) begin
      frame_pulse();
      if (!last_busy) begin
        n = p;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, flash_busy_o}, 32'd0);
    chk("rst_done", {31'b0, flash_done_o}, 32'd0);
    chk("rst_en", {31'b0, vga_data_en_o}, 32'd0);
    chk("rst_data", {8'b0, vga_data_o}, 32'd0);
    rst = 1'b0;

    // Main field geometry and colours
    gd_field[0][0] = 3'd3;
    gd_field[19][9] = 3'd7;
    gd_field[5][0] = 3'd2;
    send(302, 202, 1'b1, COLOR_BRICKS_3);
    send(300, 210, 1'b1, COLOR_BORDERS);
    send(100, 100, 1'b0, COLOR_BORDERS);
    send(332, 202, 1'b1, COLOR_BORDERS);
    send(590, 810, 1'b1, COLOR_BRICKS_7);
    send(621, 810, 1'b1, COLOR_BORDERS);
    send(622, 810, 1'b0, COLOR_BORDERS);
    send(302, 841, 1'b1, COLOR_BORDERS);
    send(302, 842, 1'b0, COLOR_BORDERS);
    send(334, 234, 1'b1, COLOR_BRICKS_0);
    flush();

    // Preview: rotation 0 is all ones so a wrong rotation select shows up
    nb_data[0] = 16'hffff;
    nb_data[1][0][0] = 4'd1;
    nb_rot = 2'd1;
    nb_color = 3'd5;
    nb_en = 1'b1;
    send(704, 234, 1'b1, COLOR_BRICKS_5);
    send(736, 234, 1'b1, COLOR_BRICKS_0);
    send(672, 202, 1'b1, COLOR_BRICKS_0);
    send(670, 202, 1'b1, COLOR_BORDERS);
    send(864, 202, 1'b0, COLOR_BORDERS);
    flush();
    nb_en = 1'b0;
    send(704, 234, 1'b1, COLOR_BRICKS_0);
    flush();

    // Flash rows 0 and 19
    start_flash(20'h80001);
    chk("flash_busy_start", {31'b0, flash_busy_o}, 32'd1);
    send(302, 202, 1'b1, COLOR_FLASH);
    send(590, 810, 1'b1, COLOR_FLASH);
    send(302, 362, 1'b1, COLOR_BRICKS_2);
    flush();
    gd_field[5][0] = 3'd4;
    send(302, 362, 1'b1, COLOR_BRICKS_4);
    flush();
    done_seen = 0;
    repeat (3) frame_pulse();
    start_flash(20'h00020);
    repeat (5) frame_pulse();
    chk("flash_busy_off", {31'b0, flash_busy_o}, 32'd1);
    send(302, 202, 1'b1, COLOR_BRICKS_0);
    send(590, 810, 1'b1, COLOR_BRICKS_0);
    send(302, 362, 1'b1, COLOR_BRICKS_4);
    flush();
    run_to_idle(n_pulses);
    chk("flash_total_frames", 32'(8 + n_pulses), 32'd48);
    chk("flash_done_at_fall", {31'b0, last_done}, 32'd1);
    chk("flash_done_once", 32'(done_seen), 32'd1);
    tick();
    chk("flash_done_drop", {31'b0, flash_done_o}, 32'd0);
    send(302, 202, 1'b1, COLOR_BRICKS_3);
    flush();

    // Zero mask is ignored
    start_flash(20'h00000);
    chk("zero_mask_busy0", {31'b0, flash_busy_o}, 32'd0);
    tick();
    chk("zero_mask_busy1", {31'b0, flash_busy_o}, 32'd0);

    // Reset in the middle of the ON phase
    start_flash(20'h00001);
    repeat (2) frame_pulse();
    send(302, 202, 1'b1, COLOR_FLASH);
    flush();
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, flash_busy_o}, 32'd0);
    chk("midrst_done", {31'b0, flash_done_o}, 32'd0);
    chk("midrst_en", {31'b0, vga_data_en_o}, 32'd0);
    chk("midrst_data", {8'b0, vga_data_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    start_flash(20'h00001);
    chk("rerun_busy", {31'b0, flash_busy_o}, 32'd1);
    run_to_idle(n_pulses);
    chk("rerun_frames", 32'(n_pulses), 32'd48);
    chk("rerun_done_once", 32'(done_seen), 32'd1);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
